acc_cpu: RTL and testbench
==========================

# acc_cpu

Parametrised accumulator CPU and the successor of the 8-bit fetch-only core. It adds configurable data and address widths, two-word instructions and a full fetch/operand/execute state machine. It also adds ALU, load/store, conditional jumps, halt and a clock-enable stall. It drives one shared memory port that addresses either program ROM or data RAM, and it sits between the top-level glue and the ROM/RAM models.

## Interface
- DATA_W, 8, accumulator/instruction word width; must be >= ADDR_W and >= 4
- ADDR_W, 8, memory address width; also the PC width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  1 = advance one FSM step this cycle; 0 = hold every register
- data_in  in  DATA_W  combinational read data for MEM[address] in the selected space, same cycle
- address  out  ADDR_W  memory address
- rom_ram  out  1  0 = address selects ROM, 1 = address selects RAM
- wr_en  out  1  RAM write strobe; RAM samples data_out at the rising edge while high
- data_out  out  DATA_W  write data (= acc)
- acc_out  out  DATA_W  accumulator value
- carry  out  1  carry/borrow flag
- halted  out  1  high in HALT state

## Operation
- Instruction layout: word at pc, with opcode = bits [3:0] and upper bits ignored. Operand word `arg` is at pc+1, both words in ROM.
- Opcodes:
  - 0 NOP
  - 1 LDI: acc=arg
  - 2 LDA: acc=RAM[arg]
  - 3 STA: RAM[arg]=acc
  - 4 ADD: acc+=RAM[arg]
  - 5 SUB: acc-=RAM[arg]
  - 6 AND, 7 OR, 8 XOR: acc op= RAM[arg]
  - 9 JMP: pc=arg
  - A JZ: jump if acc==0
  - B JC: jump if carry
  - F HLT
  - C, D, E: treated as NOP
- RAM/jump address = arg[ADDR_W-1:0].
- States:
  - FETCH_OP: address=pc, rom_ram=0; latch opcode; go to FETCH_ARG.
  - FETCH_ARG: address=pc+1, rom_ram=0; latch arg.
    - Opcode 0/1/9/A/B/C/D/E: complete here (LDI writes acc; jumps load pc). Otherwise pc<=pc+2. Go to FETCH_OP.
    - Opcode 2-8: go to EXEC with pc<=pc+2.
    - Opcode F: go to HALT, pc unchanged.
  - EXEC: address=arg, rom_ram=1. wr_en=1 only for STA. Load/ALU ops consume data_in at the edge. Go to FETCH_OP.
  - HALT: address=pc, rom_ram=0, wr_en=0; stays until reset.
- Arithmetic:
  - acc wraps mod 2^DATA_W; pc wraps mod 2^ADDR_W (pc=2^ADDR_W-1 fetches its operand from address 0).
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: carry = borrow (1 iff acc < operand before the op).
  - Only ADD/SUB modify carry. LDI/LDA/logic ops leave it unchanged.
- JZ/JC not taken: pc<=pc+2.
- en=0: state, pc, acc, carry, opcode and arg hold. Outputs keep driving the current state's values, but wr_en is forced 0 so no RAM write occurs. The interrupted step resumes when en returns to 1.

## Timing
- Reset values: state=FETCH_OP, pc=0, acc=0, carry=0, opcode=0, arg=0. Resulting outputs: address=0, rom_ram=0, wr_en=0, data_out=0, acc_out=0, carry=0, halted=0.
- reset has priority over en and applies in any state, including mid-EXEC (wr_en drops the same cycle as the reset edge takes effect).
- Latency with en=1 every cycle:
  - 2 cycles: NOP, LDI, JMP, JZ, JC.
  - 3 cycles: LDA, STA, ADD, SUB, AND, OR, XOR.
- First opcode fetch occurs in the first cycle after reset deasserts.
- acc_out and carry update on the edge ending FETCH_ARG (LDI) or EXEC (RAM ops). halted rises on the edge ending FETCH_ARG of HLT.
- All outputs are registered-state decodes. data_in is used only at the sampling edge of FETCH_OP, FETCH_ARG or EXEC.

## Test plan
- Reset, then program LDI 0x05; HLT -> FETCH_OP at pc 0,1 (cycle 1-2). acc_out=0x05 after 2 cycles; halted=1 after 4 cycles; address then holds 2.
- LDI 0xF0; STA 0x10; LDI 0x20; ADD 0x10 -> RAM[0x10]=0xF0 written with wr_en=1 for exactly one cycle (rom_ram=1, address=0x10). Final acc=0x10, carry=1.
- LDI 0x03; SUB with RAM=0x05 -> acc=0xFE, carry=1. Then JC 0x00 branches: pc=0 on the next FETCH_OP.
- LDI 0; JZ 0x20 -> next fetch address 0x20. LDI 1; JZ 0x20 -> falls through to pc+2.
- pc at 0xFE with a 2-word NOP -> pc wraps to 0x00. JMP at 0xFF fetches its operand from 0x00.
- STA in EXEC with en=0 for 3 cycles -> wr_en=0 and state frozen, then one write when en=1. Reset asserted mid-EXEC -> all outputs return to reset values next cycle and no write occurs.

Source files
------------

// File: rtl/acc_cpu.sv
// acc_cpu: parametrised accumulator CPU with two-word instructions.
// A single memory port is shared between program ROM and data RAM.
// Each instruction passes through FETCH_OP and FETCH_ARG. RAM-touching
// instructions add an EXEC step. HLT parks the core until reset.
// en=0 freezes every register and blocks RAM writes.
module acc_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] address,
  output logic              rom_ram,
  output logic              wr_en,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] acc_out,
  output logic              carry,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    EXEC      = 2'd2,
    HALT      = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [ADDR_W-1:0] arg_q, arg_d;

  // Extended-width add/subtract: the top bit is carry (ADD) or borrow (SUB).
  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;
  assign sum_ext  = {1'b0, acc_q} + {1'b0, data_in};
  assign diff_ext = {1'b0, acc_q} - {1'b0, data_in};

  // Architectural state register; en=0 holds everything, reset wins over en.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH_OP;
      pc_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      opcode_q <= OP_NOP;
      arg_q    <= '0;
    end else if (en) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      opcode_q <= opcode_d;
      arg_q    <= arg_d;
    end
  end

  // Next-state and datapath: decide what the current step commits at the edge.
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    opcode_d = opcode_q;
    arg_d    = arg_q;
    case (state_q)
      FETCH_OP: begin
        opcode_d = data_in[3:0];
        state_d  = FETCH_ARG;
      end
      FETCH_ARG: begin
        arg_d   = data_in[ADDR_W-1:0];
        state_d = FETCH_OP;
        pc_d    = pc_q + PC_TWO;
        case (opcode_q)
          OP_LDI: acc_d = data_in;
          OP_JMP: pc_d = data_in[ADDR_W-1:0];
          OP_JZ:  if (acc_q == '0) pc_d = data_in[ADDR_W-1:0];
          OP_JC:  if (carry_q) pc_d = data_in[ADDR_W-1:0];
          OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
            state_d = EXEC;
          OP_HLT: begin
            state_d = HALT;
            pc_d    = pc_q;
          end
          default: ; // NOP and unused opcodes just advance pc
        endcase
      end
      EXEC: begin
        state_d = FETCH_OP;
        case (opcode_q)
          OP_LDA: acc_d = data_in;
          OP_ADD: {carry_d, acc_d} = sum_ext;
          OP_SUB: {carry_d, acc_d} = diff_ext;
          OP_AND: acc_d = acc_q & data_in;
          OP_OR:  acc_d = acc_q | data_in;
          OP_XOR: acc_d = acc_q ^ data_in;
          default: ; // STA writes through the port, no register change
        endcase
      end
      default: ; // HALT: hold until reset
    endcase
  end

  // Memory-port and status decode from the registered state.
  always_comb begin
    address = pc_q;
    rom_ram = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      FETCH_ARG: address = pc_q + PC_ONE;
      EXEC: begin
        address = arg_q;
        rom_ram = 1'b1;
        wr_en   = en && (opcode_q == OP_STA);
      end
      default: ;
    endcase
  end

  assign data_out = acc_q;
  assign acc_out  = acc_q;
  assign carry    = carry_q;
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_acc_cpu.sv
// Testbench for acc_cpu: ROM/RAM models and directed programs.
// Stimulus queues cycle-tagged expected outputs and expected RAM writes.
// A negedge monitor pops and compares them as the DUT reaches each cycle.
module tb_acc_cpu;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b1;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] address;
  logic              rom_ram;
  logic              wr_en;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] acc_out;
  logic              carry;
  logic              halted;

  acc_cpu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in),
    .address(address), .rom_ram(rom_ram), .wr_en(wr_en),
    .data_out(data_out), .acc_out(acc_out), .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory models: ROM written by the stimulus only, RAM by this port only.
  logic [7:0] rom [256];
  logic [7:0] ram [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  assign data_in = rom_ram ? ram[address] : rom[address];

  always @(posedge clk) begin
    if (wr_en) ram[address] <= data_out;
    else if (pl_we) ram[pl_addr] <= pl_data;
  end

  typedef enum {F_ADDR, F_ROMRAM, F_WREN, F_ACC, F_CARRY, F_HALTED} field_t;
  typedef struct {
    int          cyc;
    string       name;
    field_t      f;
    logic [31:0] val;
  } exp_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  exp_t q[$];
  wr_t  wq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] field_val(input field_t f);
    case (f)
      F_ADDR:   return 32'(address);
      F_ROMRAM: return 32'(rom_ram);
      F_WREN:   return 32'(wr_en);
      F_ACC:    return 32'(acc_out);
      F_CARRY:  return 32'(carry);
      default:  return 32'(halted);
    endcase
  endfunction

  // Monitor: cycle 1 is the first cycle with reset low.
  always @(negedge clk) begin : monitor
    exp_t e;
    wr_t  w;
    if (reset) begin
      cyc = 0;
    end else begin
      cyc++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check($sformatf("%s@c%0d", e.name, e.cyc), field_val(e.f), e.val);
      end
      if (wr_en) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write@c%0d: got addr 0x%0h data 0x%0h, expected no write",
                   cyc, address, data_out);
        end else begin
          w = wq.pop_front();
          check($sformatf("write_addr@c%0d", cyc), 32'(address), 32'(w.a));
          check($sformatf("write_data@c%0d", cyc), 32'(data_out), 32'(w.d));
          check($sformatf("write_romram@c%0d", cyc), 32'(rom_ram), 32'h1);
        end
      end
    end
  end

  task automatic push(input int c, input string n, input field_t f, input logic [31:0] v);
    exp_t e;
    e.cyc = c; e.name = n; e.f = f; e.val = v;
    q.push_back(e);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
  endtask

  // Hold reset across two edges, then clear ROM.
  task automatic start_test();
    reset = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  task automatic run(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic end_test(input string name);
    check({name, "_pending_expect"}, 32'(q.size()), 32'h0);
    check({name, "_pending_writes"}, 32'(wq.size()), 32'h0);
    q.delete();
    wq.delete();
  endtask

  initial begin
    // T1: LDI 05; HLT
    start_test();
    rom[0] = 8'h01; rom[1] = 8'h05; rom[2] = 8'h0F;
    push(1, "t1_rst_addr", F_ADDR, 0);
    push(1, "t1_rst_romram", F_ROMRAM, 0);
    push(1, "t1_rst_wren", F_WREN, 0);
    push(1, "t1_rst_acc", F_ACC, 0);
    push(1, "t1_rst_carry", F_CARRY, 0);
    push(1, "t1_rst_halted", F_HALTED, 0);
    push(2, "t1_fetch_arg_addr", F_ADDR, 1);
    push(3, "t1_ldi_acc", F_ACC, 8'h05);
    push(3, "t1_fetch_hlt_addr", F_ADDR, 2);
    push(4, "t1_not_yet_halted", F_HALTED, 0);
    push(5, "t1_halted", F_HALTED, 1);
    push(8, "t1_halt_addr", F_ADDR, 2);
    push(8, "t1_halt_acc", F_ACC, 8'h05);
    run(8);
    end_test("t1");

    // T2: LDI F0; STA 10; LDI 20; ADD 10; HLT
    start_test();
    preload(8'h10, 8'h00);
    rom[0] = 8'h01; rom[1] = 8'hF0; rom[2] = 8'h03; rom[3] = 8'h10;
    rom[4] = 8'h01; rom[5] = 8'h20; rom[6] = 8'h04; rom[7] = 8'h10;
    rom[8] = 8'h0F;
    push(5, "t2_sta_addr", F_ADDR, 8'h10);
    push(5, "t2_sta_romram", F_ROMRAM, 1);
    push(5, "t2_sta_wren", F_WREN, 1);
    push(6, "t2_wren_one_cycle", F_WREN, 0);
    push(10, "t2_add_romram", F_ROMRAM, 1);
    push(10, "t2_add_no_write", F_WREN, 0);
    push(11, "t2_add_acc", F_ACC, 8'h10);
    push(11, "t2_add_carry", F_CARRY, 1);
    push(13, "t2_halted", F_HALTED, 1);
    push_wr(8'h10, 8'hF0);
    run(13);
    check("t2_ram10", 32'(ram[8'h10]), 32'hF0);
    end_test("t2");

    // T3: LDI 03; SUB 20 (RAM=05); JC 00
    start_test();
    preload(8'h20, 8'h05);
    rom[0] = 8'h01; rom[1] = 8'h03; rom[2] = 8'h05; rom[3] = 8'h20;
    rom[4] = 8'h0B; rom[5] = 8'h00;
    push(5, "t3_sub_addr", F_ADDR, 8'h20);
    push(6, "t3_sub_acc", F_ACC, 8'hFE);
    push(6, "t3_sub_borrow", F_CARRY, 1);
    push(8, "t3_jc_target", F_ADDR, 0);
    push(8, "t3_jc_romram", F_ROMRAM, 0);
    push(10, "t3_ldi_acc", F_ACC, 8'h03);
    push(10, "t3_ldi_keeps_carry", F_CARRY, 1);
    run(10);
    end_test("t3");

    // T4: LDI 0; JZ 20 (taken) / LDI 1; JZ 20 (not taken); HLT
    start_test();
    rom[0] = 8'h01; rom[1] = 8'h00; rom[2] = 8'h0A; rom[3] = 8'h20;
    rom[8'h20] = 8'h01; rom[8'h21] = 8'h01; rom[8'h22] = 8'h0A; rom[8'h23] = 8'h20;
    rom[8'h24] = 8'h0F;
    push(5, "t4_jz_taken", F_ADDR, 8'h20);
    push(9, "t4_jz_fallthrough", F_ADDR, 8'h24);
    push(11, "t4_halted", F_HALTED, 1);
    run(11);
    end_test("t4");

    // T5a: JMP FE; NOP at FE wraps pc to 00
    start_test();
    rom[0] = 8'h09; rom[1] = 8'hFE;
    push(3, "t5a_op_fe", F_ADDR, 8'hFE);
    push(4, "t5a_arg_ff", F_ADDR, 8'hFF);
    push(5, "t5a_wrap", F_ADDR, 8'h00);
    run(5);
    end_test("t5a");

    // T5b: JMP at FF takes its operand from 00; HLT with upper bits set
    start_test();
    rom[0] = 8'h09; rom[1] = 8'hFF; rom[8'hFF] = 8'h09; rom[8'h09] = 8'hAF;
    push(3, "t5b_op_ff", F_ADDR, 8'hFF);
    push(4, "t5b_arg_wrap", F_ADDR, 8'h00);
    push(5, "t5b_target", F_ADDR, 8'h09);
    push(7, "t5b_halted", F_HALTED, 1);
    push(7, "t5b_halt_addr", F_ADDR, 8'h09);
    run(7);
    end_test("t5b");

    // T6: LDI 5A; STA 30 stalled for three cycles in EXEC
    start_test();
    preload(8'h30, 8'h00);
    rom[0] = 8'h01; rom[1] = 8'h5A; rom[2] = 8'h03; rom[3] = 8'h30; rom[4] = 8'h0F;
    push(5, "t6_stall_wren", F_WREN, 0);
    push(6, "t6_stall_romram", F_ROMRAM, 1);
    push(7, "t6_stall_addr", F_ADDR, 8'h30);
    push(7, "t6_stall_wren_end", F_WREN, 0);
    push(8, "t6_resume_wren", F_WREN, 1);
    push(9, "t6_next_fetch", F_ADDR, 8'h04);
    push(9, "t6_wren_done", F_WREN, 0);
    push(11, "t6_halted", F_HALTED, 1);
    push_wr(8'h30, 8'h5A);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_ram30", 32'(ram[8'h30]), 32'h5A);
    end_test("t6");

    // T7: reset while a stalled STA sits in EXEC
    start_test();
    preload(8'h40, 8'h77);
    rom[0] = 8'h01; rom[1] = 8'h5A; rom[2] = 8'h03; rom[3] = 8'h40; rom[4] = 8'h0F;
    push(5, "t7_exec_romram", F_ROMRAM, 1);
    push(5, "t7_exec_acc", F_ACC, 8'h5A);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    push(1, "t7_rst_addr", F_ADDR, 0);
    push(1, "t7_rst_romram", F_ROMRAM, 0);
    push(1, "t7_rst_wren", F_WREN, 0);
    push(1, "t7_rst_acc", F_ACC, 0);
    push(1, "t7_rst_carry", F_CARRY, 0);
    push(1, "t7_rst_halted", F_HALTED, 0);
    push(3, "t7_frozen_addr", F_ADDR, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t7_ram40_untouched", 32'(ram[8'h40]), 32'h77);
    end_test("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
